// File: rtl/twiddle_rotator_stage3_pkg.sv
// Shared constants and types for the stage-3 twiddle rotator and its complex multiplier.
package twiddle_rotator_stage3_pkg;

  localparam int unsigned TW_FRAC = 12;
  localparam int          TW_ONE  = 1 << TW_FRAC;
  localparam int unsigned ROM_LAT = 1;
  localparam longint      ROUND_K = longint'(1) << (TW_FRAC - 1);

  typedef struct packed {
    logic valid;
    logic sof;
  } tag_t;

  function automatic longint round_k(input int unsigned frac);
    return longint'(1) << (frac - 1);
  endfunction

  function automatic longint sat_hi(input int unsigned dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int unsigned dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/twiddle_rotator_stage3_cmul.sv
// Two-stage registered complex multiply (a * w) with round-half-up and saturation.
module cmul_round_sat
  import twiddle_rotator_stage3_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned TW      = 14,
  parameter int unsigned TW_FRAC = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_mul,
  input  logic                 en_out,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [TW-1:0] w_cos,
  input  logic signed [TW-1:0] w_sin,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im
);

  localparam int unsigned PW = DW + TW;
  localparam int unsigned AW = PW + 1;
  localparam int unsigned SW = AW - TW_FRAC;
  localparam logic signed [AW-1:0] RND = AW'(round_k(TW_FRAC));
  localparam logic signed [SW-1:0] HI  = SW'(sat_hi(DW));
  localparam logic signed [SW-1:0] LO  = SW'(sat_lo(DW));

  logic signed [PW-1:0] p_rc, p_is, p_rs, p_ic;
  logic signed [AW-1:0] acc_re, acc_im;
  logic signed [SW-1:0] sh_re, sh_im;

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > HI)      return HI[DW-1:0];
    else if (v < LO) return LO[DW-1:0];
    else             return v[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (en_mul) begin
      p_rc <= PW'(a_re) * PW'(w_cos);
      p_is <= PW'(a_im) * PW'(w_sin);
      p_rs <= PW'(a_re) * PW'(w_sin);
      p_ic <= PW'(a_im) * PW'(w_cos);
    end
  end

  // Slicing off the fraction bits is the arithmetic shift right by TW_FRAC.
  always_comb begin
    acc_re = {p_rc[PW-1], p_rc} - {p_is[PW-1], p_is} + RND;
    acc_im = {p_rs[PW-1], p_rs} + {p_ic[PW-1], p_ic} + RND;
    sh_re  = acc_re[AW-1:TW_FRAC];
    sh_im  = acc_im[AW-1:TW_FRAC];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_re <= '0;
      y_im <= '0;
    end else if (en_out) begin
      y_re <= sat(sh_re);
      y_im <= sat(sh_im);
    end
  end

endmodule

// File: rtl/twiddle_rotator_stage3.sv
// Stage-3 twiddle rotator: DIF twiddle addressing over 8-sample sub-blocks, 3-cycle rotate.
module twiddle_rotator_stage3
  import twiddle_rotator_stage3_pkg::*;
#(
  parameter int unsigned N    = 256,
  parameter int unsigned SIZE = 8,
  parameter int unsigned DW   = 16,
  parameter int unsigned TW   = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic signed [DW-1:0]   in_re,
  input  logic signed [DW-1:0]   in_im,
  output logic        [SIZE-3:0] tw_addr,
  output logic                   tw_en,
  input  logic signed [TW-1:0]   tw_cos,
  input  logic signed [TW-1:0]   tw_sin,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic signed [DW-1:0]   out_re,
  output logic signed [DW-1:0]   out_im
);

  if (N != (1 << SIZE) || ROM_LAT != 1) begin : g_param_check
    $error("twiddle_rotator_stage3: N must be 2**SIZE and ROM latency must be 1");
  end

  logic [2:0]          cnt, cnt_eff;
  logic [1:0]          idx;
  logic signed [DW-1:0] d_re, d_im;
  tag_t                t1, t2;

  // Upper half of the sub-block uses twiddle index r; lower half uses index 0.
  always_comb begin
    cnt_eff = in_sof ? '0 : cnt;
    idx     = cnt_eff[2] ? cnt_eff[1:0] : 2'd0;
    tw_en   = in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      tw_addr <= '0;
    end else if (in_valid) begin
      cnt     <= cnt_eff + 3'd1;
      tw_addr <= (SIZE-2)'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      d_re <= in_re;
      d_im <= in_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t1        <= '0;
      t2        <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      t1        <= '{valid: in_valid, sof: in_valid & in_sof};
      t2        <= t1;
      out_valid <= t2.valid;
      out_sof   <= t2.sof;
    end
  end

  cmul_round_sat #(
    .DW      (DW),
    .TW      (TW),
    .TW_FRAC (TW_FRAC)
  ) u_cmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_mul (t1.valid),
    .en_out (t2.valid),
    .a_re   (d_re),
    .a_im   (d_im),
    .w_cos  (tw_cos),
    .w_sin  (tw_sin),
    .y_re   (out_re),
    .y_im   (out_im)
  );

endmodule

// File: tb/tb_twiddle_rotator_stage3.sv
// Scoreboard bench for twiddle_rotator_stage3 with a 1-cycle twiddle ROM model.
module tb_twiddle_rotator_stage3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_sof;
  logic signed [15:0] in_re, in_im;
  logic        [5:0]  tw_addr;
  logic               tw_en;
  logic signed [13:0] tw_cos, tw_sin;
  logic               out_valid, out_sof;
  logic signed [15:0] out_re, out_im;

  typedef struct {
    logic        sof;
    int          re;
    int          im;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  twiddle_rotator_stage3 #(.N(256), .SIZE(8), .DW(16), .TW(14)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr), .tw_en(tw_en),
    .tw_cos(tw_cos), .tw_sin(tw_sin), .out_valid(out_valid), .out_sof(out_sof),
    .out_re(out_re), .out_im(out_im)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM stores W = cos + j*sin with sin already negated.
  always_comb begin
    case (tw_addr)
      6'd0:    begin tw_cos = 14'sd4096;  tw_sin = 14'sd0;     end
      6'd1:    begin tw_cos = 14'sd2896;  tw_sin = -14'sd2896; end
      6'd2:    begin tw_cos = 14'sd0;     tw_sin = -14'sd4096; end
      6'd3:    begin tw_cos = -14'sd2896; tw_sin = -14'sd2896; end
      default: begin tw_cos = 14'sd0;     tw_sin = 14'sd0;     end
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_re", out_re, e.re);
        chk("out_im", out_im, e.im);
        chk("out_sof", out_sof, e.sof);
        chk("latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic issue(input logic v, input logic sof, input int re, input int im,
                       input int exp_addr, input int exp_re, input int exp_im);
    exp_t e;
    in_valid = v;
    in_sof   = sof;
    in_re    = 16'(re);
    in_im    = 16'(im);
    if (v) begin
      e.sof = sof; e.re = exp_re; e.im = exp_im; e.cyc = cyc;
      q.push_back(e);
    end
    #1;
    chk("tw_en", tw_en, v);
    @(posedge clk);
    #1;
    if (v) chk("tw_addr", tw_addr, exp_addr);
  endtask

  // {valid, sof, re, im, addr, exp_re, exp_im}
  int vec_a [16][7] = '{
    '{1,1,   -5,    7, 0,    -5,    7},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 1,   707, -707},
    '{1,0, 1000,  500, 2,   500,-1000},
    '{1,0, 1000,    0, 3,  -707, -707},
    '{1,1, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0,32767,32767, 1, 32767,    0},
    '{1,0, 1000,    0, 2,     0,-1000},
    '{1,0, 1000,    0, 3,  -707, -707}
  };

  // Gaps every other cycle; in_sof during gaps must be ignored.
  int vec_g [13][7] = '{
    '{1,1,  1000,     0, 0,   1000,    0},
    '{0,1,     0,     0, 0,      0,    0},
    '{1,0,  1000,     0, 0,   1000,    0},
    '{0,1,     0,     0, 0,      0,    0},
    '{1,0,  1000,     0, 0,   1000,    0},
    '{0,0,     0,     0, 0,      0,    0},
    '{1,0,  1000,     0, 0,   1000,    0},
    '{0,1,     0,     0, 0,      0,    0},
    '{1,0,  1000,     0, 0,   1000,    0},
    '{0,1,     0,     0, 0,      0,    0},
    '{1,0,-32768,-32768, 1, -32768,    0},
    '{0,0,     0,     0, 0,      0,    0},
    '{1,0,  1000,   500, 2,    500,-1000}
  };

  // After reset: no sof at first, then a mid-sub-block sof restarts the index.
  int vec_r [12][7] = '{
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 1,   707, -707},
    '{1,1,   -5,    7, 0,    -5,    7},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0, 1000,    0, 0,  1000,    0},
    '{1,0,32767,32767, 1, 32767,    0}
  };

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_tw_addr", tw_addr, 0);
    rst_n = 1'b1;

    foreach (vec_a[i])
      issue(vec_a[i][0][0], vec_a[i][1][0], vec_a[i][2], vec_a[i][3],
            vec_a[i][4], vec_a[i][5], vec_a[i][6]);
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    foreach (vec_g[i])
      issue(vec_g[i][0][0], vec_g[i][1][0], vec_g[i][2], vec_g[i][3],
            vec_g[i][4], vec_g[i][5], vec_g[i][6]);

    // Last gap-phase sample is still in flight here and must be discarded.
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_re", out_re, 0);
    chk("midrst_out_im", out_im, 0);
    chk("midrst_tw_addr", tw_addr, 0);
    chk("midrst_inflight", q.size(), 1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vec_r[i])
      issue(vec_r[i][0][0], vec_r[i][1][0], vec_r[i][2], vec_r[i][3],
            vec_r[i][4], vec_r[i][5], vec_r[i][6]);
    in_valid = 1'b0; in_sof = 1'b0;

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
